// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port among NR_REQ requesters.
// One requester owns the port per transaction (IDLE -> REQ -> RESP). Its
// payload is steered to the m_* port, and the response goes back only to it.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin arbitration).
// Without this macro, arbitration is fixed priority and the lowest index wins.
module mem_arbiter #(
   parameter int NR_REQ = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   localparam int ID_W   = $clog2(NR_REQ),
   localparam int MASK_W = DATA_W / 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NR_REQ-1:0]          req_valid,
   output logic [NR_REQ-1:0]          req_ready,
   input  logic [NR_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NR_REQ-1:0]          req_wen,
   input  logic [NR_REQ*DATA_W-1:0]   req_wdata,
   input  logic [NR_REQ*MASK_W-1:0]   req_wmask,
   output logic [NR_REQ-1:0]          resp_valid,
   input  logic [NR_REQ-1:0]          resp_ready,
   output logic [DATA_W-1:0]          resp_rdata,
   output logic                       m_req_valid,
   input  logic                       m_req_ready,
   output logic [ADDR_W-1:0]          m_addr,
   output logic                       m_wen,
   output logic [DATA_W-1:0]          m_wdata,
   output logic [MASK_W-1:0]          m_wmask,
   input  logic                       m_resp_valid,
   output logic                       m_resp_ready,
   input  logic [DATA_W-1:0]          m_rdata,
   output logic [ID_W-1:0]            grant_id
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;
   logic [ID_W-1:0]   winner;
   logic              any_req;

   // Per-requester payload views, indexed by the owner id.
   logic [ADDR_W-1:0] addr_arr  [NR_REQ];
   logic [DATA_W-1:0] wdata_arr [NR_REQ];
   logic [MASK_W-1:0] wmask_arr [NR_REQ];

   for (genvar gi = 0; gi < NR_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
      assign wmask_arr[gi] = req_wmask[gi*MASK_W +: MASK_W];
   end

   assign any_req  = |req_valid;
   assign grant_id = grant_id_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

   // Round-robin pick: first requester above the pointer, else wrap to the lowest index.
   always_comb begin
      logic found;
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < NR_REQ; i++) begin
         if (!found && req_valid[i] && (ID_W'(i) > rr_ptr_q)) begin
            found  = 1'b1;
            winner = ID_W'(i);
         end
      end
      for (int i = 0; i < NR_REQ; i++) begin
         if (!found && req_valid[i] && (ID_W'(i) <= rr_ptr_q)) begin
            found  = 1'b1;
            winner = ID_W'(i);
         end
      end
   end

   // Pointer follows the winner when the grant is taken.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (state_q == IDLE && any_req) begin
         rr_ptr_d = winner;
      end
   end

   // Pointer register; reset value makes requester 0 the first winner.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q <= ID_W'(NR_REQ - 1);
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`else
   // Fixed-priority pick: the lowest set index wins.
   always_comb begin
      winner = '0;
      for (int i = NR_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            winner = ID_W'(i);
         end
      end
   end
`endif

   // State and owner registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
      end
   end

   // Next state, owner capture, and combinational steering of the owner's handshakes and payload.
   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      req_ready    = '0;
      resp_valid   = '0;
      resp_rdata   = '0;
      m_req_valid  = 1'b0;
      m_resp_ready = 1'b0;
      m_addr       = '0;
      m_wen        = 1'b0;
      m_wdata      = '0;
      m_wmask      = '0;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_id_d = winner;
               state_d    = REQ;
            end
         end
         REQ: begin
            m_req_valid           = 1'b1;
            m_addr                = addr_arr[grant_id_q];
            m_wen                 = req_wen[grant_id_q];
            m_wdata               = wdata_arr[grant_id_q];
            m_wmask               = wmask_arr[grant_id_q];
            req_ready[grant_id_q] = m_req_ready;
            if (m_req_ready) begin
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid[grant_id_q] = m_resp_valid;
            m_resp_ready           = resp_ready[grant_id_q];
            resp_rdata             = m_rdata;
            if (m_resp_valid && resp_ready[grant_id_q]) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (NR_REQ=2, 32-bit address and data).
// Expected grant order follows MEM_ARB_ROUND_ROBIN_EN if it is defined.
module tb_mem_arbiter;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [63:0]   req_addr;
   logic [1:0]    req_wen;
   logic [63:0]   req_wdata;
   logic [7:0]    req_wmask;
   logic [1:0]    resp_valid;
   logic [1:0]    resp_ready;
   logic [31:0]   resp_rdata;
   logic          m_req_valid;
   logic          m_req_ready;
   logic [31:0]   m_addr;
   logic          m_wen;
   logic [31:0]   m_wdata;
   logic [3:0]    m_wmask;
   logic          m_resp_valid;
   logic          m_resp_ready;
   logic [31:0]   m_rdata;
   logic [0:0]    grant_id;

   int checks   = 0;
   int failures = 0;

   mem_arbiter #(.NR_REQ(2), .ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_wen      (req_wen),
      .req_wdata    (req_wdata),
      .req_wmask    (req_wmask),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .m_req_valid  (m_req_valid),
      .m_req_ready  (m_req_ready),
      .m_addr       (m_addr),
      .m_wen        (m_wen),
      .m_wdata      (m_wdata),
      .m_wmask      (m_wmask),
      .m_resp_valid (m_resp_valid),
      .m_resp_ready (m_resp_ready),
      .m_rdata      (m_rdata),
      .grant_id     (grant_id)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs are then driven for the new cycle.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      req_valid    = '0;
      req_addr     = '0;
      req_wen      = '0;
      req_wdata    = '0;
      req_wmask    = '0;
      resp_ready   = '0;
      m_req_ready  = 1'b0;
      m_resp_valid = 1'b0;
      m_rdata      = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      req_valid   = 2'b11;
      m_req_ready = 1'b1;
      resp_ready  = 2'b11;
      tick();
      tick();
      #1;
      checks++;
      if (req_ready !== 2'b00 || resp_valid !== 2'b00 || m_req_valid !== 1'b0 || m_resp_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_handshakes: req_ready=%b resp_valid=%b m_req_valid=%b m_resp_ready=%b required all 0",
                  req_ready, resp_valid, m_req_valid, m_resp_ready);
      end
      checks++;
      if (grant_id !== 1'b0) begin
         failures++;
         $display("FAIL reset_grant_id: got %0d required 0", grant_id);
      end
      rst_n = 1'b1;
      tick();
      #1;
      checks++;
      if (m_req_valid !== 1'b1 || grant_id !== 1'b0) begin
         failures++;
         $display("FAIL reset_first_grant: m_req_valid=%b grant_id=%0d required 1/0", m_req_valid, grant_id);
      end
      $display("reset: first grant=%0d", grant_id);
   endtask

   task automatic test_single_read();
      do_reset();
      req_valid         = 2'b01;
      req_addr[31:0]    = 32'h8000_0000;
      req_addr[63:32]   = 32'h1111_1111;
      #1;
      checks++;
      if (m_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL read_idle_valid: m_req_valid=%b required 0", m_req_valid);
      end
      tick();
      m_req_ready = 1'b1;
      #1;
      checks++;
      if (m_req_valid !== 1'b1 || m_addr !== 32'h8000_0000 || m_wen !== 1'b0 || req_ready !== 2'b01) begin
         failures++;
         $display("FAIL read_req: m_req_valid=%b m_addr=%h m_wen=%b req_ready=%b required 1/80000000/0/01",
                  m_req_valid, m_addr, m_wen, req_ready);
      end
      tick();
      req_valid    = 2'b00;
      m_req_ready  = 1'b0;
      m_resp_valid = 1'b1;
      m_rdata      = 32'hDEAD_BEEF;
      resp_ready   = 2'b01;
      #1;
      checks++;
      if (resp_valid !== 2'b01 || resp_rdata !== 32'hDEAD_BEEF || m_resp_ready !== 1'b1) begin
         failures++;
         $display("FAIL read_resp: resp_valid=%b resp_rdata=%h m_resp_ready=%b required 01/deadbeef/1",
                  resp_valid, resp_rdata, m_resp_ready);
      end
      checks++;
      if (m_addr !== 32'h0 || m_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL read_payload_zero: m_addr=%h m_req_valid=%b required 0/0", m_addr, m_req_valid);
      end
      tick();
      m_resp_valid = 1'b0;
      #1;
      checks++;
      if (m_req_valid !== 1'b0 || resp_valid !== 2'b00) begin
         failures++;
         $display("FAIL read_back_idle: m_req_valid=%b resp_valid=%b required 0/00", m_req_valid, resp_valid);
      end
      $display("single_read: addr=80000000 rdata=%h", resp_rdata);
   endtask

   task automatic test_back_to_back();
      int exp_order[4];
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      do_reset();
      req_valid    = 2'b11;
      m_req_ready  = 1'b1;
      m_resp_valid = 1'b1;
      resp_ready   = 2'b11;
      for (int t = 0; t < 4; t++) begin
         tick();
         #1;
         checks++;
         if (grant_id !== 1'(exp_order[t]) || m_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_grant[%0d]: grant_id=%0d m_req_valid=%b required %0d/1",
                     t, grant_id, m_req_valid, exp_order[t]);
         end
         tick();
         #1;
         checks++;
         if (resp_valid !== (exp_order[t] == 1 ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL b2b_resp[%0d]: resp_valid=%b required onehot of %0d", t, resp_valid, exp_order[t]);
         end
         tick();
         $display("back_to_back: txn %0d granted to %0d", t, grant_id);
      end
      clear_inputs();
   endtask

   task automatic test_backpressure();
      int req_hs  = 0;
      int resp_hs = 0;
      do_reset();
      req_valid        = 2'b10;
      req_addr[63:32]  = 32'h1000_0040;
      req_addr[31:0]   = 32'hAAAA_0000;
      req_wdata[63:32] = 32'hCAFE_F00D;
      tick();
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (m_req_valid !== 1'b1 || req_ready !== 2'b00 || grant_id !== 1'b1 || m_addr !== 32'h1000_0040) begin
            failures++;
            $display("FAIL bp_req_hold[%0d]: m_req_valid=%b req_ready=%b grant_id=%0d m_addr=%h required 1/00/1/10000040",
                     c, m_req_valid, req_ready, grant_id, m_addr);
         end
         if (req_valid[1] && req_ready[1]) req_hs++;
         tick();
      end
      m_req_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
         failures++;
         $display("FAIL bp_req_accept: req_ready=%b required 10", req_ready);
      end
      if (req_valid[1] && req_ready[1]) req_hs++;
      tick();
      req_valid    = 2'b00;
      m_req_ready  = 1'b0;
      m_resp_valid = 1'b1;
      m_rdata      = 32'h0BAD_CAFE;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (resp_valid !== 2'b10 || m_resp_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_resp_hold[%0d]: resp_valid=%b m_resp_ready=%b required 10/0", c, resp_valid, m_resp_ready);
         end
         if (resp_valid[1] && resp_ready[1]) resp_hs++;
         tick();
      end
      resp_ready = 2'b10;
      #1;
      checks++;
      if (m_resp_ready !== 1'b1 || resp_rdata !== 32'h0BAD_CAFE) begin
         failures++;
         $display("FAIL bp_resp_accept: m_resp_ready=%b resp_rdata=%h required 1/0badcafe", m_resp_ready, resp_rdata);
      end
      if (resp_valid[1] && resp_ready[1]) resp_hs++;
      tick();
      m_resp_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         if (req_valid[1] && req_ready[1]) req_hs++;
         if (resp_valid[1] && resp_ready[1]) resp_hs++;
         tick();
      end
      checks++;
      if (req_hs != 1 || resp_hs != 1) begin
         failures++;
         $display("FAIL bp_handshake_count: req_hs=%0d resp_hs=%0d required 1/1", req_hs, resp_hs);
      end
      $display("backpressure: req handshakes=%0d resp handshakes=%0d", req_hs, resp_hs);
      clear_inputs();
   endtask

   task automatic test_write_isolation();
      do_reset();
      req_valid        = 2'b10;
      req_wen          = 2'b10;
      req_addr[63:32]  = 32'h2000_0010;
      req_addr[31:0]   = 32'hFFFF_FFFF;
      req_wdata[63:32] = 32'h1234_5678;
      req_wdata[31:0]  = 32'h5555_5555;
      req_wmask        = 8'b0011_1111;
      resp_ready       = 2'b11;
      tick();
      m_req_ready = 1'b1;
      #1;
      checks++;
      if (m_wen !== 1'b1 || m_wmask !== 4'b0011 || m_wdata !== 32'h1234_5678 || m_addr !== 32'h2000_0010) begin
         failures++;
         $display("FAIL wr_payload: m_wen=%b m_wmask=%b m_wdata=%h m_addr=%h required 1/0011/12345678/20000010",
                  m_wen, m_wmask, m_wdata, m_addr);
      end
      checks++;
      if (req_ready !== 2'b10) begin
         failures++;
         $display("FAIL wr_req_ready: req_ready=%b required 10", req_ready);
      end
      tick();
      req_valid    = 2'b00;
      m_req_ready  = 1'b0;
      m_resp_valid = 1'b1;
      #1;
      checks++;
      if (resp_valid !== 2'b10 || req_ready !== 2'b00) begin
         failures++;
         $display("FAIL wr_isolation: resp_valid=%b req_ready=%b required 10/00", resp_valid, req_ready);
      end
      tick();
      $display("write_isolation: wdata=12345678 wmask=0011");
      clear_inputs();
   endtask

   task automatic test_mid_reset();
      do_reset();
      req_valid  = 2'b11;
      resp_ready = 2'b11;
      tick();
      m_req_ready = 1'b1;
      #1;
      checks++;
      if (grant_id !== 1'b0) begin
         failures++;
         $display("FAIL mr_first_grant: grant_id=%0d required 0", grant_id);
      end
      tick();
      req_valid   = 2'b10;
      m_req_ready = 1'b0;
      #1;
      checks++;
      if (m_resp_ready !== 1'b1) begin
         failures++;
         $display("FAIL mr_in_resp: m_resp_ready=%b required 1", m_resp_ready);
      end
      rst_n = 1'b0;
      tick();
      #1;
      checks++;
      if (m_resp_ready !== 1'b0 || m_req_valid !== 1'b0 || grant_id !== 1'b0) begin
         failures++;
         $display("FAIL mr_after_reset: m_resp_ready=%b m_req_valid=%b grant_id=%0d required 0/0/0",
                  m_resp_ready, m_req_valid, grant_id);
      end
      rst_n = 1'b1;
      tick();
      #1;
      checks++;
      if (m_req_valid !== 1'b1 || grant_id !== 1'b1) begin
         failures++;
         $display("FAIL mr_rearb: m_req_valid=%b grant_id=%0d required 1/1", m_req_valid, grant_id);
      end
      $display("mid_reset: re-arbitrated to %0d", grant_id);
      clear_inputs();
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      tick();
      test_reset();
      test_single_read();
      test_back_to_back();
      test_backpressure();
      test_write_isolation();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
